// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the state type used by the RTL and available to the bench.
package subtractor_pkg;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_SHIFT = 1'b1;

    typedef enum logic {
        IDLE  = STATE_IDLE,
        SHIFT = STATE_SHIFT
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: computes x - y - bin, giving the difference bit
// and the borrow into the next more significant bit.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d - 2^WIDTH*b_out = a - b - b_in, one bit per clock,
// LSB first, with a one-cycle done pulse when the result is loaded.
module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] next_result;
    logic             borrow;
    logic [CNT_W-1:0] count;
    logic             bit_diff;
    logic             bit_borrow;
    logic             last_bit;

    full_subtractor u_fs (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (borrow),
        .diff (bit_diff),
        .bout (bit_borrow)
    );

    // New difference bits enter at the MSB so the LSB-first stream ends aligned.
    assign next_result = (result >> 1) | (WIDTH'(bit_diff) << (WIDTH - 1));
    assign last_bit    = (count == CNT_W'(WIDTH - 1));
    assign busy        = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last_bit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            result <= '0;
            borrow <= 1'b0;
            count  <= '0;
            d      <= '0;
            b_out  <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= b_in;
                        result <= '0;
                        count  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    result <= next_result;
                    borrow <= bit_borrow;
                    count  <= count + 1'b1;
                    // The final bit edge publishes the result and pulses done.
                    if (last_bit) begin
                        d     <= next_result;
                        b_out <= bit_borrow;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random self-checking bench for serial_subtractor (WIDTH=4),
// with expected results worked out by hand or by a 5-bit arithmetic model.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       b_in;
    logic       busy;
    logic       done;
    logic [3:0] d;
    logic       b_out;

    int total;
    int bad;
    int cyc;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .b_out (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Runs one full operation checking busy/done each cycle; when disturb is set,
    // a second start with other operands is pulsed at edge k+2 and must be ignored.
    task automatic applyStimulus(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                                 input logic [3:0] exp_d, input logic exp_bout,
                                 input logic disturb, input string tag);
        a     = ia;
        b     = ib;
        b_in  = ibin;
        start = 1'b1;
        step();
        checkOutput({tag, "_busy_k"}, 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (disturb && i == 2) begin
                start = 1'b1;
                a     = 4'b1111;
                b     = 4'b0001;
                b_in  = 1'b1;
            end
            if (disturb && i == 3) start = 1'b0;
            step();
            if (i < 4) begin
                checkOutput({tag, "_done_early"}, 32'(done), 32'd0);
                checkOutput({tag, "_busy_mid"}, 32'(busy), 32'd1);
            end else begin
                checkOutput({tag, "_done"}, 32'(done), 32'd1);
                checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
                checkOutput({tag, "_d"}, 32'(d), 32'(exp_d));
                checkOutput({tag, "_bout"}, 32'(b_out), 32'(exp_bout));
            end
        end
        step();
        checkOutput({tag, "_done_drop"}, 32'(done), 32'd0);
        checkOutput({tag, "_d_hold"}, 32'(d), 32'(exp_d));
    endtask

    task automatic waitDone(output int at);
        at = -1;
        for (int n = 0; n < 20; n++) begin
            step();
            if (done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int         t0;
        int         t1;
        int         t2;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rbin;
        logic [4:0] model;

        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        b_in  = 1'b0;
        step();
        step();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_d", 32'(d), 32'd0);
        checkOutput("rst_bout", 32'(b_out), 32'd0);
        rst = 1'b0;
        step();

        applyStimulus(4'b0111, 4'b0011, 1'b0, 4'b0100, 1'b0, 1'b0, "sub_7_3");
        applyStimulus(4'b0011, 4'b0111, 1'b0, 4'b1100, 1'b1, 1'b0, "sub_3_7");
        applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, "sub_0_0_bin");
        applyStimulus(4'b1010, 4'b0011, 1'b0, 4'b0111, 1'b0, 1'b1, "ignore_start");
        step();
        checkOutput("ignore_start_idle", 32'(busy), 32'd0);

        // Reset two edges into an operation: outputs clear and no done follows.
        a     = 4'b1000;
        b     = 4'b0001;
        b_in  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_d", 32'(d), 32'd0);
        checkOutput("abort_bout", 32'(b_out), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput("abort_no_done", 32'(done), 32'd0);
        end

        // Reset and start on the same edge: start is dropped.
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        step();
        checkOutput("rst_over_start", 32'(busy), 32'd0);

        // Start held high through the done cycle: second op follows 5 cycles later.
        a     = 4'b1001;
        b     = 4'b0100;
        b_in  = 1'b0;
        start = 1'b1;
        step();
        t0   = cyc;
        a    = 4'b0010;
        b    = 4'b0101;
        b_in = 1'b1;
        waitDone(t1);
        checkOutput("b2b_first_lat", 32'(t1 - t0), 32'd4);
        checkOutput("b2b_first_d", 32'(d), 32'b0101);
        checkOutput("b2b_first_bout", 32'(b_out), 32'd0);
        step();
        start = 1'b0;
        checkOutput("b2b_second_busy", 32'(busy), 32'd1);
        checkOutput("b2b_d_stable", 32'(d), 32'b0101);
        waitDone(t2);
        checkOutput("b2b_spacing", 32'(t2 - t1), 32'd5);
        checkOutput("b2b_second_d", 32'(d), 32'b1100);
        checkOutput("b2b_second_bout", 32'(b_out), 32'd1);
        step();

        for (int n = 0; n < 100; n++) begin
            ra    = 4'($urandom_range(0, 15));
            rb    = 4'($urandom_range(0, 15));
            rbin  = 1'($urandom_range(0, 1));
            model = {1'b0, ra} - {1'b0, rb} - 5'(rbin);
            applyStimulus(ra, rb, rbin, model[3:0], model[4], 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
